// File: rtl/seg_display_pkg.sv
// Shared constants, segment type and hex-to-cathode table for the 4-digit scan display.
package seg_display_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns, indexed by hex nibble
    localparam seg_t HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Bus between a host and the display scan controller: load path in, scan outputs out.
interface display_scan_ctrl_if;
    import seg_display_pkg::*;

    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        load;
    logic [1:0]  digit_sel;
    seg_t        seg;
    logic        dp;
    logic        tick;

    modport master (
        output data_in, dp_in, load,
        input  digit_sel, seg, dp, tick
    );

    modport slave (
        input  data_in, dp_in, load,
        output digit_sel, seg, dp, tick
    );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment cathode decoder.
module hex_to_seg7
    import seg_display_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment scan controller with tear-free frame latching.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits 0..2.
module display_scan_ctrl
    import seg_display_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int SCAN_HZ = 4_000
) (
    input  logic               clk,
    input  logic               rst_n,
    display_scan_ctrl_if.slave bus
);

    localparam int DIV     = CLK_HZ / SCAN_HZ;
    localparam int PRESC_W = $clog2(DIV);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(DIV - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [1:0]         digit_sel_q, digit_sel_d;
    seg_t               seg_q, seg_d;
    logic               dp_q, dp_d;
    logic               tick_q, tick_d;
    logic [15:0]        pend_data_q, pend_data_d;
    logic [3:0]         pend_dp_q, pend_dp_d;
    logic [15:0]        frame_data_q, frame_data_d;
    logic [3:0]         frame_dp_q, frame_dp_d;

    logic       wrap;
    logic       boundary;
    logic [1:0] next_idx;
    logic [3:0] next_nib;
    logic       next_dp;
    logic       next_blank;
    seg_t       dec_seg;

    assign wrap     = (presc_q == PRESC_MAX);
    assign next_idx = digit_sel_q + 2'd1;
    assign boundary = wrap && (digit_sel_q == 2'(NUM_DIGITS - 1));

    // Frame/pending update and selection of the digit about to be shown.
    // The mux reads frame_data_d so a load on the boundary cycle is visible on digit 0.
    always_comb begin
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        frame_data_d = frame_data_q;
        frame_dp_d   = frame_dp_q;
        next_nib     = 4'h0;
        next_dp      = 1'b0;
        next_blank   = 1'b0;

        if (bus.load) begin
            pend_data_d = bus.data_in;
            pend_dp_d   = bus.dp_in;
        end
        if (boundary) begin
            frame_data_d = bus.load ? bus.data_in : pend_data_q;
            frame_dp_d   = bus.load ? bus.dp_in   : pend_dp_q;
        end

        case (next_idx)
            2'd0: begin
                next_nib   = frame_data_d[15:12];
                next_dp    = frame_dp_d[3];
                next_blank = (frame_data_d[15:12] == 4'h0);
            end
            2'd1: begin
                next_nib   = frame_data_d[11:8];
                next_dp    = frame_dp_d[2];
                next_blank = (frame_data_d[15:8] == 8'h00);
            end
            2'd2: begin
                next_nib   = frame_data_d[7:4];
                next_dp    = frame_dp_d[1];
                next_blank = (frame_data_d[15:4] == 12'h000);
            end
            default: begin
                next_nib   = frame_data_d[3:0];
                next_dp    = frame_dp_d[0];
                next_blank = 1'b0;
            end
        endcase
    end

    hex_to_seg7 u_dec (
        .nibble (next_nib),
        .seg    (dec_seg)
    );

    always_comb begin
        presc_d     = wrap ? '0 : presc_q + 1'b1;
        digit_sel_d = digit_sel_q;
        seg_d       = seg_q;
        dp_d        = dp_q;
        tick_d      = wrap;

        if (wrap) begin
            digit_sel_d = next_idx;
            dp_d        = ~next_dp;
`ifdef SEG_LEADING_ZERO_BLANK_EN
            seg_d       = next_blank ? SEG_BLANK : dec_seg;
`else
            seg_d       = dec_seg;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q      <= '0;
            digit_sel_q  <= 2'b11;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            tick_q       <= 1'b0;
            pend_data_q  <= 16'h0000;
            pend_dp_q    <= 4'b0000;
            frame_data_q <= 16'h0000;
            frame_dp_q   <= 4'b0000;
        end else begin
            presc_q      <= presc_d;
            digit_sel_q  <= digit_sel_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            tick_q       <= tick_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            frame_data_q <= frame_data_d;
            frame_dp_q   <= frame_dp_d;
        end
    end

    assign bus.digit_sel = digit_sel_q;
    assign bus.seg       = seg_q;
    assign bus.dp        = dp_q;
    assign bus.tick      = tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: expected digits are queued as loads are issued.
module tb_display_scan_ctrl;

    typedef struct {
        logic [1:0] digit;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   tick_gap = 0;
    exp_t sb[$];

    display_scan_ctrl_if dif ();

    display_scan_ctrl #(
        .CLK_HZ  (8),
        .SCAN_HZ (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] hex_lut(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    task automatic push_frame(input logic [15:0] data, input logic [3:0] dpv);
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            logic [15:0] upper;
            upper   = data >> (12 - 4 * i);
            e.digit = 2'(i);
            e.seg   = hex_lut(upper[3:0]);
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (i < 3 && upper == 16'h0) e.seg = 7'h7F;
`endif
            e.dp    = ~dpv[3 - i];
            sb.push_back(e);
        end
    endtask

    task automatic wait_tick();
        bit seen = 1'b0;
        for (int n = 0; n < 16 && !seen; n++) begin
            @(posedge clk);
            #1;
            if (dif.tick === 1'b1) seen = 1'b1;
        end
        chk("tick_wait", 32'(seen), 32'd1);
    endtask

    task automatic do_load(input logic [15:0] data, input logic [3:0] dpv);
        dif.data_in = data;
        dif.dp_in   = dpv;
        dif.load    = 1'b1;
        @(posedge clk);
        #1;
        dif.load    = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_digit"}, 32'(dif.digit_sel), 32'd3);
        chk({tag, "_seg"},   32'(dif.seg),       32'h7F);
        chk({tag, "_dp"},    32'(dif.dp),        32'd1);
        chk({tag, "_tick"},  32'(dif.tick),      32'd0);
    endtask

    always @(posedge clk) begin
        if (!rst_n || dif.tick === 1'b1) tick_gap <= (!rst_n) ? 0 : 1;
        else tick_gap <= tick_gap + 1;
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && dif.tick === 1'b1) begin
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            chk("tick_spacing", 32'(tick_gap), 32'd4);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("scan_digit", 32'(dif.digit_sel), 32'(e.digit));
                chk("scan_seg",   32'(dif.seg),       32'(e.seg));
                chk("scan_dp",    32'(dif.dp),        32'(e.dp));
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        dif.load    = 1'b0;
        dif.data_in = 16'h0000;
        dif.dp_in   = 4'b0000;

        // Reset held 3 clocks, then released; outputs hold reset values until the first step
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_frame(16'h0000, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_reset_state("rst_hold");
        end
        wait_tick();

        // Load mid-frame: shown from the next frame onwards
        push_frame(16'h1A8F, 4'b0010);
        do_load(16'h1A8F, 4'b0010);
        repeat (5) wait_tick();
        chk("at_digit1", 32'(dif.digit_sel), 32'd1);

        // Load zero while on digit 1: digits 2,3 keep the old frame
        push_frame(16'h0000, 4'b0000);
        do_load(16'h0000, 4'b0000);
        repeat (6) wait_tick();
        chk("at_digit3", 32'(dif.digit_sel), 32'd3);

        // Load exactly in the boundary cycle: bypass into the frame being started
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("pre_boundary_digit", 32'(dif.digit_sel), 32'd3);
        push_frame(16'hFFFF, 4'b1001);
        do_load(16'hFFFF, 4'b1001);
        chk("bypass_tick", 32'(dif.tick), 32'd1);
        chk("bypass_seg", 32'(dif.seg), 32'h0E);

        // Reset pulse while on digit 2 discards the rest of the frame
        repeat (2) wait_tick();
        chk("at_digit2", 32'(dif.digit_sel), 32'd2);
        @(posedge clk);
        #1;
        sb.delete();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_reset_state("midscan_rst");
        push_frame(16'h0000, 4'b0000);
        wait_tick();

        // Value with leading zeros
        push_frame(16'h0070, 4'b0000);
        do_load(16'h0070, 4'b0000);
        repeat (7) wait_tick();

        @(negedge clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
